// File: rtl/reset_ctrl_pkg.sv
// Shared types for the reset controller: FSM states and per-source edge modes.
package reset_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOCK    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_LEVEL = 2'b01,
    MODE_RISE  = 2'b10,
    MODE_FALL  = 2'b11
  } edge_mode_t;

  // Quiescent level of a source: falling-edge sources idle high.
  function automatic logic idle_level(edge_mode_t mode);
    return (mode == MODE_FALL);
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// One reset source: synchroniser chain, stable-count debouncer, edge/level event.
module reset_debounce
  import reset_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter edge_mode_t  MODE            = MODE_FALL
) (
  input  logic clk,
  input  logic reset,
  input  logic src_in,
  output logic src_event
);

  localparam logic           IDLE     = idle_level(MODE);
  localparam int unsigned    CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_nxt;
  logic                   level_q;
  logic                   level_nxt;
  logic                   event_nxt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // Metastability chain, preset to the idle level so reset release is quiet.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= {SYNC_STAGES{IDLE}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], src_in};
  end

  // Level follows the synchronised input only after DEBOUNCE_CYCLES straight mismatches.
  always_comb begin
    level_nxt = level_q;
    cnt_nxt   = '0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) level_nxt = synced;
      else                   cnt_nxt   = cnt_q + CW'(1);
    end
  end

  // Event decode on the level about to be registered, giving a one-cycle registered event.
  always_comb begin
    event_nxt = 1'b0;
    case (MODE)
      MODE_LEVEL: event_nxt = level_nxt;
      MODE_RISE:  event_nxt = level_nxt & ~level_q;
      MODE_FALL:  event_nxt = ~level_nxt & level_q;
      default:    event_nxt = 1'b0;
    endcase
  end

  // Debounce state and registered event output.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      level_q   <= IDLE;
      src_event <= 1'b0;
    end else begin
      cnt_q     <= cnt_nxt;
      level_q   <= level_nxt;
      src_event <= event_nxt;
    end
  end

endmodule

// File: rtl/reset_controller.sv
// System reset sequencer: waits for PLL lock, stretches sys_reset, restarts on source
// or software events, and records sticky causes plus a saturating event count.
module reset_controller
  import reset_ctrl_pkg::*;
#(
  parameter int unsigned         NUM_SRC         = 2,
  parameter int unsigned         SYNC_STAGES     = 2,
  parameter int unsigned         DEBOUNCE_CYCLES = 16,
  parameter int unsigned         STRETCH_CYCLES  = 256,
  parameter logic [2*NUM_SRC-1:0] EDGE_MODE      = {NUM_SRC{2'b11}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               sw_reset_req,
  input  logic               cause_clear,
  output logic               sys_reset,
  output logic               ready,
  output logic [NUM_SRC+1:0] reset_cause,
  output logic [7:0]         reset_count
);

  localparam int unsigned   SW          = $clog2(STRETCH_CYCLES);
  localparam logic [SW-1:0] STRETCH_END = SW'(STRETCH_CYCLES - 1);

  ctrl_state_t          state_q;
  logic [SW-1:0]        stretch_cnt;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [NUM_SRC-1:0]   src_event;
  logic [NUM_SRC+1:0]   cause_set;
  logic                 lock_ok;
  logic                 any_event;
  logic                 count_inc;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    reset_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .MODE            (edge_mode_t'(EDGE_MODE[2*i +: 2]))
    ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .src_in    (src_in[i]),
      .src_event (src_event[i])
    );
  end

  // PLL lock synchroniser; lock is assumed absent until proven.
  always_ff @(posedge clk) begin
    if (reset) lock_sync_q <= '0;
    else       lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign lock_ok   = lock_sync_q[SYNC_STAGES-1];
  assign any_event = (|src_event) | sw_reset_req;

  // Cause and count qualification: nothing is recorded while in LOCK; lock loss masks events.
  always_comb begin
    cause_set = '0;
    count_inc = 1'b0;
    if (state_q != ST_LOCK) begin
      if (!lock_ok) cause_set[NUM_SRC+1] = 1'b1;
      else          cause_set = {1'b0, sw_reset_req, src_event};
      count_inc = (state_q == ST_RUN) && (!lock_ok || any_event);
    end
  end

  // Sequencer FSM with registered outputs; priority is lock loss, then events, then stretch end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOCK;
      stretch_cnt <= '0;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      reset_cause <= '0;
      reset_count <= '0;
    end else begin
      case (state_q)
        ST_LOCK: begin
          if (lock_ok) begin
            state_q     <= ST_STRETCH;
            stretch_cnt <= '0;
          end
        end
        ST_STRETCH, ST_RUN: begin
          if (!lock_ok) begin
            state_q     <= ST_LOCK;
            stretch_cnt <= '0;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
          end else if (any_event) begin
            state_q     <= ST_STRETCH;
            stretch_cnt <= '0;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
          end else if (state_q == ST_STRETCH) begin
            if (stretch_cnt == STRETCH_END) begin
              state_q     <= ST_RUN;
              stretch_cnt <= '0;
              sys_reset   <= 1'b0;
              ready       <= 1'b1;
            end else begin
              stretch_cnt <= stretch_cnt + SW'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_LOCK;
          stretch_cnt <= '0;
          sys_reset   <= 1'b1;
          ready       <= 1'b0;
        end
      endcase

      reset_cause <= (cause_clear ? '0 : reset_cause) | cause_set;
      if (count_inc && (reset_count != 8'hFF)) reset_count <= reset_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_reset_controller.sv
// Directed scoreboard bench for reset_controller: stimulus threads queue expected
// snapshots keyed by cycle; monitors compare at those cycles and flag any
// sys_reset edge that nobody predicted.
module tb_reset_controller;

  logic       clk = 1'b0;
  int         cyc = 0;

  logic       reset, pll_locked, sw_reset_req, cause_clear;
  logic [1:0] src_in;
  logic       sys_reset, ready;
  logic [3:0] reset_cause;
  logic [7:0] reset_count;

  logic       reset2, pll_locked2, sw_reset_req2;
  logic       sys_reset2, ready2;
  logic [3:0] reset_cause2;
  logic [7:0] reset_count2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cyc;
    bit         is_edge;
    logic       sr;
    logic       rd;
    logic [3:0] cause;
    logic [7:0] count;
    string      name;
  } exp_t;

  typedef struct {
    int         cyc;
    logic       sr;
    logic [7:0] count;
    string      name;
  } exp2_t;

  exp_t  q[$];
  exp2_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reset_controller #(
    .NUM_SRC         (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16),
    .STRETCH_CYCLES  (256),
    .EDGE_MODE       (4'b1111)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pll_locked   (pll_locked),
    .src_in       (src_in),
    .sw_reset_req (sw_reset_req),
    .cause_clear  (cause_clear),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .reset_cause  (reset_cause),
    .reset_count  (reset_count)
  );

  reset_controller #(
    .NUM_SRC         (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16),
    .STRETCH_CYCLES  (2),
    .EDGE_MODE       (4'b1111)
  ) dut_sat (
    .clk          (clk),
    .reset        (reset2),
    .pll_locked   (pll_locked2),
    .src_in       (2'b11),
    .sw_reset_req (sw_reset_req2),
    .cause_clear  (1'b0),
    .sys_reset    (sys_reset2),
    .ready        (ready2),
    .reset_cause  (reset_cause2),
    .reset_count  (reset_count2)
  );

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int c, input bit e, input logic sr, input logic rd,
                           input logic [3:0] ca, input logic [7:0] cn, input string nm);
    exp_t x;
    x.cyc = c; x.is_edge = e; x.sr = sr; x.rd = rd; x.cause = ca; x.count = cn; x.name = nm;
    q.push_back(x);
  endtask

  task automatic expect2_at(input int c, input logic sr, input logic [7:0] cn, input string nm);
    exp2_t x;
    x.cyc = c; x.sr = sr; x.count = cn; x.name = nm;
    q2.push_back(x);
  endtask

  // Main monitor.
  initial begin : mon_main
    logic prev_sr;
    bit   changed;
    bit   matched;
    exp_t x;
    prev_sr = 1'b1;
    forever begin
      @(negedge clk);
      changed = (sys_reset !== prev_sr);
      prev_sr = sys_reset;
      matched = 1'b0;
      while (q.size() > 0 && q[0].cyc == cyc) begin
        x = q.pop_front();
        n_checks++;
        if (sys_reset !== x.sr || ready !== x.rd || reset_cause !== x.cause || reset_count !== x.count) begin
          n_fail++;
          $display("FAIL %s @%0d: got sys_reset=%b ready=%b cause=%b count=%0d, want sys_reset=%b ready=%b cause=%b count=%0d",
                   x.name, cyc, sys_reset, ready, reset_cause, reset_count, x.sr, x.rd, x.cause, x.count);
        end
        if (x.is_edge) begin
          matched = 1'b1;
          n_checks++;
          if (!changed) begin
            n_fail++;
            $display("FAIL %s_edge @%0d: sys_reset did not toggle this cycle (now %b)", x.name, cyc, sys_reset);
          end
        end
      end
      if (changed && !matched) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_edge @%0d: sys_reset toggled to %b, no transition expected", cyc, sys_reset);
      end
      if (q.size() > 0 && q[0].cyc < cyc) begin
        x = q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never evaluated (now %0d)", x.name, x.cyc, cyc);
      end
    end
  end

  // Saturation monitor.
  initial begin : mon_sat
    exp2_t x;
    forever begin
      @(negedge clk);
      while (q2.size() > 0 && q2[0].cyc == cyc) begin
        x = q2.pop_front();
        n_checks++;
        if (sys_reset2 !== x.sr || reset_count2 !== x.count) begin
          n_fail++;
          $display("FAIL %s @%0d: got sys_reset=%b count=%0d, want sys_reset=%b count=%0d",
                   x.name, cyc, sys_reset2, reset_count2, x.sr, x.count);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, required end by 1800", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1; pll_locked = 1'b0; src_in = 2'b11; sw_reset_req = 1'b0; cause_clear = 1'b0;
    reset2 = 1'b1; pll_locked2 = 1'b1; sw_reset_req2 = 1'b0;

    fork
      begin : main_seq
        expect_at(3, 0, 1'b1, 1'b0, 4'b0000, 8'd0, "reset_state");
        wait_cyc(4);  reset = 1'b0;

        wait_cyc(10); pll_locked = 1'b1;
        expect_at(268, 0, 1'b1, 1'b0, 4'b0000, 8'd0, "lock_stretch_hold");
        expect_at(269, 1, 1'b0, 1'b1, 4'b0000, 8'd0, "lock_release");

        wait_cyc(280); src_in[0] = 1'b0;
        wait_cyc(290); src_in[0] = 1'b1;
        expect_at(330, 0, 1'b0, 1'b1, 4'b0000, 8'd0, "short_glitch");

        wait_cyc(340); src_in[0] = 1'b0;
        expect_at(358, 0, 1'b0, 1'b1, 4'b0000, 8'd0, "src_pre_event");
        expect_at(359, 1, 1'b1, 1'b0, 4'b0001, 8'd1, "src_event");
        expect_at(615, 1, 1'b0, 1'b1, 4'b0001, 8'd1, "src_run");
        wait_cyc(360); src_in[0] = 1'b1;

        wait_cyc(630); sw_reset_req = 1'b1; cause_clear = 1'b1;
        expect_at(631, 1, 1'b1, 1'b0, 4'b0100, 8'd2, "sw_and_clear");
        wait_cyc(631); sw_reset_req = 1'b0; cause_clear = 1'b0;

        wait_cyc(700); sw_reset_req = 1'b1;
        expect_at(702, 0, 1'b1, 1'b0, 4'b0100, 8'd2, "sw_in_stretch");
        expect_at(887, 0, 1'b1, 1'b0, 4'b0100, 8'd2, "stretch_restarted");
        expect_at(957, 1, 1'b0, 1'b1, 4'b0100, 8'd2, "run_after_restart");
        wait_cyc(701); sw_reset_req = 1'b0;

        wait_cyc(980); cause_clear = 1'b1;
        expect_at(982, 0, 1'b0, 1'b1, 4'b0000, 8'd2, "cause_clear");
        wait_cyc(981); cause_clear = 1'b0;

        wait_cyc(1000); sw_reset_req = 1'b1;
        expect_at(1001, 1, 1'b1, 1'b0, 4'b0100, 8'd3, "sw_from_run");
        wait_cyc(1001); sw_reset_req = 1'b0;

        wait_cyc(1099); pll_locked = 1'b0;
        expect_at(1103, 0, 1'b1, 1'b0, 4'b1100, 8'd3, "lock_loss_stretch");

        wait_cyc(1120); pll_locked = 1'b1;
        expect_at(1378, 0, 1'b1, 1'b0, 4'b1100, 8'd3, "relock_hold");
        expect_at(1379, 1, 1'b0, 1'b1, 4'b1100, 8'd3, "relock_release");

        wait_cyc(1400); pll_locked = 1'b0;
        expect_at(1403, 1, 1'b1, 1'b0, 4'b1100, 8'd4, "lock_loss_run");

        wait_cyc(1410); cause_clear = 1'b1;
        expect_at(1412, 0, 1'b1, 1'b0, 4'b0000, 8'd4, "clear_in_lock");
        wait_cyc(1411); cause_clear = 1'b0;

        wait_cyc(1415); sw_reset_req = 1'b1;
        expect_at(1418, 0, 1'b1, 1'b0, 4'b0000, 8'd4, "sw_ignored_lock");
        wait_cyc(1416); sw_reset_req = 1'b0;

        wait_cyc(1420); pll_locked = 1'b1;

        wait_cyc(1450); reset = 1'b1;
        expect_at(1452, 0, 1'b1, 1'b0, 4'b0000, 8'd0, "reset_mid_stretch");
        wait_cyc(1452); reset = 1'b0;
        expect_at(1710, 0, 1'b1, 1'b0, 4'b0000, 8'd0, "post_reset_hold");
        expect_at(1711, 1, 1'b0, 1'b1, 4'b0000, 8'd0, "post_reset_release");

        wait_cyc(1720);
      end
      begin : sat_seq
        wait_cyc(4); reset2 = 1'b0;
        expect2_at(15, 1'b0, 8'd0, "sat_initial_run");
        for (int k = 0; k < 300; k++) begin
          wait_cyc(20 + 4 * k);
          sw_reset_req2 = 1'b1;
          if (k == 0 || k == 1 || k == 253 || k == 254 || k == 255 || k == 299)
            expect2_at(21 + 4 * k, 1'b1, (k >= 254) ? 8'd255 : 8'(k + 1), "sat_count");
          wait_cyc(21 + 4 * k);
          sw_reset_req2 = 1'b0;
        end
        wait_cyc(1230);
      end
    join

    wait_cyc(1725);
    n_checks++;
    if (q.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations: %0d/%0d left unevaluated, required 0/0", q.size(), q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
